// File: rtl/mac_tcdm_responder_pkg.sv
// mac_tcdm_responder_package: shared address-map helpers and request/response records
// for the banked TCDM responder.
package mac_tcdm_responder_package;

    function automatic int bank_bits(input int nb);
        return $clog2(nb);
    endfunction

    function automatic int row_bits(input int bank_words);
        return $clog2(bank_words);
    endfunction

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } tcdm_req_t;

    typedef struct packed {
        logic [31:0] r_data;
        logic        r_valid;
    } tcdm_resp_t;

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// hwpe_stream_intf_tcdm: single TCDM request/response channel between a master and a slave.
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/mac_tcdm_rr_arb.sv
// mac_tcdm_rr_arb: per-bank round-robin arbiter; grants the first requester at or after
// the pointer, then moves the pointer just past the winner.
module mac_tcdm_rr_arb #(
    parameter int MP = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          stall_i,
    input  logic [MP-1:0] req_i,
    output logic [MP-1:0] gnt_o
);
    localparam int PW = (MP > 1) ? $clog2(MP) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Scan from the farthest offset down so the nearest requester overwrites the rest.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        sum   = '0;
        idx   = '0;
        if (!stall_i && !clear_i) begin
            for (int k = MP - 1; k >= 0; k--) begin
                sum = {1'b0, ptr_q} + (PW + 1)'(k);
                idx = (sum >= (PW + 1)'(MP)) ? PW'(sum - (PW + 1)'(MP)) : sum[PW-1:0];
                if (req_i[idx]) begin
                    gnt_o      = '0;
                    gnt_o[idx] = 1'b1;
                    ptr_d      = (idx == PW'(MP - 1)) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= clear_i ? '0 : ptr_d;
    end
endmodule

// File: rtl/mac_tcdm_responder.sv
// mac_tcdm_responder: word-interleaved multi-bank SRAM serving MP TCDM ports with
// per-bank round-robin, same-cycle grant and a fixed one-cycle response.
module mac_tcdm_responder
    import mac_tcdm_responder_package::*;
#(
    parameter int MP         = 4,
    parameter int NB         = 4,
    parameter int BANK_WORDS = 256,
    parameter int AW         = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic stall_i,
    hwpe_stream_intf_tcdm.slave tcdm [MP]
);
    localparam int BB = bank_bits(NB);
    localparam int RB = row_bits(BANK_WORDS);

    tcdm_req_t     req_s  [MP];
    logic [MP-1:0] req_v, gnt;
    logic [BB-1:0] bank   [MP];
    logic [RB-1:0] row    [MP];
    tcdm_resp_t    resp_q [MP], resp_d [MP];
    logic [MP-1:0] breq   [NB], bgnt [NB];
    logic [RB-1:0] wrow   [NB];
    tcdm_req_t     wreq   [NB];
    logic [31:0]   mem    [NB][BANK_WORDS];

    for (genvar p = 0; p < MP; p++) begin : g_port
        logic unused_add;
        assign req_v[p] = tcdm[p].req & rst_ni;
        assign req_s[p] = '{add: tcdm[p].add, wen: tcdm[p].wen, be: tcdm[p].be, data: tcdm[p].data};
        assign bank[p]  = req_s[p].add[2+:BB];
        assign row[p]   = req_s[p].add[2+BB+:RB];
        // Bits above the bank/row field alias onto the same storage.
        assign unused_add = ^{req_s[p].add[1:0], req_s[p].add[AW-1:2+BB+RB]};
        assign tcdm[p].gnt     = gnt[p];
        assign tcdm[p].r_data  = resp_q[p].r_data;
        assign tcdm[p].r_valid = resp_q[p].r_valid;
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        for (genvar p = 0; p < MP; p++) begin : g_req
            assign breq[b][p] = req_v[p] && (bank[p] == BB'(b));
        end
        mac_tcdm_rr_arb #(.MP(MP)) i_arb (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .stall_i (stall_i),
            .req_i   (breq[b]),
            .gnt_o   (bgnt[b])
        );
    end

    always_comb begin
        gnt = '0;
        for (int b = 0; b < NB; b++) begin
            wrow[b] = '0;
            wreq[b] = '0;
            for (int p = 0; p < MP; p++) begin
                if (bgnt[b][p]) begin
                    wrow[b] = row[p];
                    wreq[b] = req_s[p];
                end
            end
            gnt = gnt | bgnt[b];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (|bgnt[b] && !wreq[b].wen) begin
                for (int i = 0; i < 4; i++) begin
                    if (wreq[b].be[i]) mem[b][wrow[b]][8*i+:8] <= wreq[b].data[8*i+:8];
                end
            end
        end
    end

    // Read data is captured at the grant edge, so a write granted the same edge elsewhere
    // never disturbs it and r_data stays put until the next grant.
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            resp_d[p]         = resp_q[p];
            resp_d[p].r_valid = gnt[p];
            if (gnt[p]) resp_d[p].r_data = req_s[p].wen ? mem[bank[p]][row[p]] : '0;
            if (clear_i) resp_d[p] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        for (int p = 0; p < MP; p++) begin
            if (!rst_ni) resp_q[p] <= '0;
            else         resp_q[p] <= resp_d[p];
        end
    end
endmodule
